// File: rtl/bcam_mbist_cm_seq_pkg.sv
// ---------------------------------------------------------------------------
// bcam_mbist_cm_seq_pkg
// Shared types and helpers for the BCAM MBIST compare-data sequencer.
//   mask_mode_e   : encoding of BIST_MASK_MODE_RF_IN
//   sweep_state_e : states of the autonomous mask-sweep FSM
//   rotl_by()     : rotate-left of the low 'width' bits of a vector
// ---------------------------------------------------------------------------
package bcam_mbist_cm_seq_pkg;

    typedef enum logic [1:0] {
        WALK1 = 2'b00,
        WALK0 = 2'b01,
        CHKBD = 2'b10,
        ZERO  = 2'b11
    } mask_mode_e;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SWEEP = 2'b01,
        DONE  = 2'b10
    } sweep_state_e;

    // Widest vector rotl_by can handle; RF_DWIDTH must not exceed this.
    localparam int unsigned ROT_MAXW = 512;
    typedef logic [ROT_MAXW-1:0] rotvec_t;

    // Rotate the low 'width' bits of vec left by amt (mod width); bits above
    // 'width' in the result are zero. Callers zero-extend into and truncate
    // out of rotvec_t.
    function automatic rotvec_t rotl_by(input rotvec_t vec,
                                        input int unsigned amt,
                                        input int unsigned width);
        rotvec_t     wmask;
        int unsigned a;
        wmask = ~(rotvec_t'('1) << width);
        a     = amt % width;
        if (a == 0) begin
            rotl_by = vec & wmask;
        end else begin
            rotl_by = ((vec << a) | (vec >> (width - a))) & wmask;
        end
    endfunction

endpackage

// File: rtl/bcam_mbist_cm_seq_mask_gen.sv
// ---------------------------------------------------------------------------
// bcam_mbist_mask_gen
// Owns the base mask register and step counter, decodes the mask mode into
// the effective (port-0) mask, and optionally captures scan data into the
// mask register for ATPG observability.
// Optional feature macro: BCAM_MBIST_CM_SEQ_ATPG_CAPTURE_EN
//
// Ports:
//   clk_i, rst_ni      clock, asynchronous active-low reset
//   load_init_i        reload initial pattern, step = 0
//   advance_i          rotate mask left by MASK_GROUP, step++ (wraps)
//   mode_i             mask mode (mask_mode_e encoding)
//   fscan_i            scan mode (used only with the ATPG macro)
//   capture_data_i     data captured into the mask in scan mode
//   eff_mask_o         effective mask after mode decode
//   step_o             current step index
// ---------------------------------------------------------------------------
module bcam_mbist_mask_gen
    import bcam_mbist_cm_seq_pkg::*;
#(
    parameter int unsigned RF_DWIDTH  = 72,
    parameter int unsigned MASK_GROUP = 1,
    parameter int unsigned NSTEPS     = 72,
    parameter int unsigned SW         = 7
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 load_init_i,
    input  logic                 advance_i,
    input  logic [1:0]           mode_i,
    input  logic                 fscan_i,
    input  logic [RF_DWIDTH-1:0] capture_data_i,
    output logic [RF_DWIDTH-1:0] eff_mask_o,
    output logic [SW-1:0]        step_o
);

    localparam int unsigned INIT_BITS = (MASK_GROUP < RF_DWIDTH) ? MASK_GROUP : RF_DWIDTH;
    localparam logic [RF_DWIDTH-1:0] INIT_PAT = {RF_DWIDTH{1'b1}} >> (RF_DWIDTH - INIT_BITS);

    logic [RF_DWIDTH-1:0] mask_q, mask_d;
    logic [SW-1:0]        step_q, step_d;
    mask_mode_e           mode_q, mode_in;
    logic                 mode_change;
    logic [RF_DWIDTH-1:0] chk_even;

    assign mode_in     = mask_mode_e'(mode_i);
    // Compared against last cycle's mode so a mode switch restarts the walk.
    assign mode_change = (mode_in != mode_q);

    always_comb begin
        mask_d = mask_q;
        step_d = step_q;
        if (load_init_i || mode_change) begin
            mask_d = INIT_PAT;
            step_d = '0;
        end else if (advance_i) begin
            mask_d = RF_DWIDTH'(rotl_by(rotvec_t'(mask_q), MASK_GROUP, RF_DWIDTH));
            step_d = (step_q == SW'(NSTEPS - 1)) ? '0 : step_q + SW'(1);
        end
`ifdef BCAM_MBIST_CM_SEQ_ATPG_CAPTURE_EN
        else if (fscan_i) begin
            mask_d = capture_data_i;
        end
`endif
    end

`ifndef BCAM_MBIST_CM_SEQ_ATPG_CAPTURE_EN
    logic unused_atpg;
    assign unused_atpg = ^{fscan_i, capture_data_i};
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mask_q <= INIT_PAT;
            step_q <= '0;
            mode_q <= WALK1;
        end else begin
            mask_q <= mask_d;
            step_q <= step_d;
            mode_q <= mode_in;
        end
    end

    // Checkerboard: odd bit positions set ("1010.." read MSB first).
    always_comb begin
        chk_even = '0;
        for (int unsigned i = 0; i < RF_DWIDTH; i++) begin
            chk_even[i] = ((i % 2) == 1);
        end
    end

    always_comb begin
        eff_mask_o = '0;
        unique case (mode_in)
            WALK1:   eff_mask_o = mask_q;
            WALK0:   eff_mask_o = ~mask_q;
            CHKBD:   eff_mask_o = step_q[0] ? ~chk_even : chk_even;
            ZERO:    eff_mask_o = '0;
            default: eff_mask_o = '0;
        endcase
    end

    assign step_o = step_q;

endmodule

// File: rtl/bcam_mbist_cm_seq.sv
// ---------------------------------------------------------------------------
// bcam_mbist_cm_seq
// BCAM MBIST input handler: generates write data and per-port CAM compare
// data, with manual mask rotation and an autonomous mask-sweep FSM.
// Optional feature macro: BCAM_MBIST_CM_SEQ_ATPG_CAPTURE_EN (scan capture of
// CM_DATA_RF_IN_P0 into the mask register).
//
// Ports:
//   bist_clk, rst_b              clock, asynchronous active-low reset
//   BIST_CM_MODE_RF_IN           1: generated compare data, 0: pass-through
//   BIST_MASK_MODE_RF_IN         walk-1 / walk-0 / checkerboard / all-zero
//   BIST_ROTATE_MASK_RF_IN       manual one-step mask advance
//   BIST_SWEEP_START_RF_IN       start an automatic sweep
//   BIST_CD_MASK_ENABLE_RF_IN    apply mask to compare data
//   BIST_DATA_INV_RF_IN          invert write data
//   FSCAN_MODE, CM_DATA_RF_IN_P0 scan mode / scan capture data
//   BIST_WR_DATA_RF_IN/OUT       write data in/out (combinational)
//   BIST_CM_DATA_RF_IN/OUT       compare data in / registered out
//   BIST_CM_VALID_RF_OUT         registered compare-valid
//   BIST_SWEEP_BUSY/DONE_RF_OUT  sweep status
//   BIST_MASK_STEP_RF_OUT        current mask step index
// ---------------------------------------------------------------------------
module bcam_mbist_cm_seq
    import bcam_mbist_cm_seq_pkg::*;
#(
    parameter  int unsigned RF_DWIDTH  = 72,
    parameter  int unsigned WR_PORTS   = 1,
    parameter  int unsigned CM_PORTS   = 2,
    parameter  int unsigned MASK_GROUP = 1,
    localparam int unsigned NSTEPS     = (RF_DWIDTH + MASK_GROUP - 1) / MASK_GROUP,
    localparam int unsigned SW         = (NSTEPS > 1) ? $clog2(NSTEPS) : 1
) (
    input  logic                               bist_clk,
    input  logic                               rst_b,
    input  logic                               BIST_CM_MODE_RF_IN,
    input  logic [1:0]                         BIST_MASK_MODE_RF_IN,
    input  logic                               BIST_ROTATE_MASK_RF_IN,
    input  logic                               BIST_SWEEP_START_RF_IN,
    input  logic                               BIST_CD_MASK_ENABLE_RF_IN,
    input  logic                               BIST_DATA_INV_RF_IN,
    input  logic                               FSCAN_MODE,
    input  logic [WR_PORTS-1:0][RF_DWIDTH-1:0] BIST_WR_DATA_RF_IN,
    input  logic [CM_PORTS-1:0][RF_DWIDTH-1:0] BIST_CM_DATA_RF_IN,
    input  logic [RF_DWIDTH-1:0]               CM_DATA_RF_IN_P0,
    output logic [WR_PORTS-1:0][RF_DWIDTH-1:0] BIST_WR_DATA_RF_OUT,
    output logic [CM_PORTS-1:0][RF_DWIDTH-1:0] BIST_CM_DATA_RF_OUT,
    output logic                               BIST_CM_VALID_RF_OUT,
    output logic                               BIST_SWEEP_BUSY_RF_OUT,
    output logic                               BIST_SWEEP_DONE_RF_OUT,
    output logic [SW-1:0]                      BIST_MASK_STEP_RF_OUT
);

    sweep_state_e                       state_q, state_d;
    logic                               start_acc, rot_acc, advance, last_step;
    logic [RF_DWIDTH-1:0]               eff_mask;
    logic [SW-1:0]                      step;
    logic [CM_PORTS-1:0][RF_DWIDTH-1:0] port_mask;
    logic [CM_PORTS-1:0][RF_DWIDTH-1:0] cm_d, cm_q;
    logic                               valid_d, valid_q;

    always_comb begin
        BIST_WR_DATA_RF_OUT = '0;
        for (int unsigned w = 0; w < WR_PORTS; w++) begin
            BIST_WR_DATA_RF_OUT[w] = BIST_WR_DATA_RF_IN[w] ^ {RF_DWIDTH{BIST_DATA_INV_RF_IN}};
        end
    end

    assign last_step = (step == SW'(NSTEPS - 1));

    // Sweep FSM. The sweep owns the mask, so manual rotate is dropped in
    // SWEEP, and START beats a simultaneous rotate in IDLE.
    always_comb begin
        state_d   = state_q;
        start_acc = 1'b0;
        rot_acc   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (BIST_SWEEP_START_RF_IN) begin
                    state_d   = SWEEP;
                    start_acc = 1'b1;
                end else begin
                    rot_acc = BIST_ROTATE_MASK_RF_IN;
                end
            end
            SWEEP: begin
                if (last_step) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
                rot_acc = BIST_ROTATE_MASK_RF_IN;
            end
            default: state_d = IDLE;
        endcase
    end

    assign advance = (state_q == SWEEP) || rot_acc;
    assign valid_d = advance;

    bcam_mbist_mask_gen #(
        .RF_DWIDTH  (RF_DWIDTH),
        .MASK_GROUP (MASK_GROUP),
        .NSTEPS     (NSTEPS),
        .SW         (SW)
    ) u_mask_gen (
        .clk_i          (bist_clk),
        .rst_ni         (rst_b),
        .load_init_i    (start_acc),
        .advance_i      (advance),
        .mode_i         (BIST_MASK_MODE_RF_IN),
        .fscan_i        (FSCAN_MODE),
        .capture_data_i (CM_DATA_RF_IN_P0),
        .eff_mask_o     (eff_mask),
        .step_o         (step)
    );

    always_comb begin
        port_mask = '0;
        cm_d      = '0;
        for (int unsigned p = 0; p < CM_PORTS; p++) begin
            port_mask[p] = RF_DWIDTH'(rotl_by(rotvec_t'(eff_mask), p * MASK_GROUP, RF_DWIDTH));
            cm_d[p] = BIST_CM_MODE_RF_IN
                    ? (({RF_DWIDTH{BIST_CD_MASK_ENABLE_RF_IN}} & port_mask[p]) ^ BIST_WR_DATA_RF_OUT[0])
                    : BIST_CM_DATA_RF_IN[p];
        end
    end

    always_ff @(posedge bist_clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q <= IDLE;
            cm_q    <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cm_q    <= cm_d;
            valid_q <= valid_d;
        end
    end

    assign BIST_CM_DATA_RF_OUT    = cm_q;
    assign BIST_CM_VALID_RF_OUT   = valid_q;
    assign BIST_SWEEP_BUSY_RF_OUT = (state_q == SWEEP);
    assign BIST_SWEEP_DONE_RF_OUT = (state_q == DONE);
    assign BIST_MASK_STEP_RF_OUT  = step;

endmodule
